// File: rtl/datapath_sequencer_pkg.sv
// rtl/datapath_sequencer_pkg.sv - shared constants for the datapath sequencer
package datapath_sequencer_pkg;

  localparam int DW_DEFAULT = 4;
  localparam int AW_DEFAULT = 2;
  localparam int FS_W       = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t EXEC = 2'd1;
  localparam state_t WB   = 2'd2;

  // Function-unit select codes shared with benches and assemblers
  localparam logic [FS_W-1:0] FS_PASS_A = 4'b0000;
  localparam logic [FS_W-1:0] FS_INC    = 4'b0001;
  localparam logic [FS_W-1:0] FS_ADD    = 4'b0010;
  localparam logic [FS_W-1:0] FS_SUB    = 4'b0101;
  localparam logic [FS_W-1:0] FS_AND    = 4'b1000;
  localparam logic [FS_W-1:0] FS_OR     = 4'b1010;
  localparam logic [FS_W-1:0] FS_XOR    = 4'b1100;

endpackage

// File: rtl/datapath_sequencer_if.sv
// rtl/datapath_sequencer_if.sv - instruction channel between initiator and sequencer
interface datapath_sequencer_if
  import datapath_sequencer_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
);
  logic            InstValid;
  logic            InstReady;
  logic            InstImm;
  logic [FS_W-1:0] InstFS;
  logic [AW-1:0]   InstRd;
  logic [AW-1:0]   InstRa;
  logic [AW-1:0]   InstRb;
  logic [DW-1:0]   ImmData;

  modport master (
    output InstValid, InstImm, InstFS, InstRd, InstRa, InstRb, ImmData,
    input  InstReady
  );

  modport slave (
    input  InstValid, InstImm, InstFS, InstRd, InstRa, InstRb, ImmData,
    output InstReady
  );
endinterface

// File: rtl/datapath_sequencer_reg_file.sv
// rtl/datapath_sequencer_reg_file.sv - 2**AW x DW register file, one write port, three read ports
module datapath_sequencer_reg_file
  import datapath_sequencer_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign ra_data  = regs[ra];
  assign rb_data  = regs[rb];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - issues one instruction at a time to the function unit and writes back
module datapath_sequencer
  import datapath_sequencer_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  datapath_sequencer_if.slave inst,
  output logic [DW-1:0]       Adata,
  output logic [DW-1:0]       Bdata,
  output logic [FS_W-1:0]     FS,
  input  logic [DW-1:0]       Fout,
  output logic                Done,
  output logic                Zero,
  input  logic [AW-1:0]       DbgAddr,
  output logic [DW-1:0]       DbgData
);

  state_t          state;
  logic [FS_W-1:0] fs_q;
  logic [AW-1:0]   rd_q;
  logic [AW-1:0]   ra_q;
  logic [AW-1:0]   rb_q;
  logic [DW-1:0]   result_q;
  logic [DW-1:0]   ra_data;
  logic [DW-1:0]   rb_data;
  logic            accept;
  logic            exec_active;
  logic            wb_active;

  // Gating with rst keeps the bus quiet and suppresses writeback while reset is held
  assign inst.InstReady = (state == IDLE) && !rst;
  assign accept         = inst.InstValid && inst.InstReady;
  assign exec_active    = (state == EXEC) && !rst;
  assign wb_active      = (state == WB) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fs_q     <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      result_q <= '0;
      Zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            fs_q <= inst.InstFS;
            rd_q <= inst.InstRd;
            ra_q <= inst.InstRa;
            rb_q <= inst.InstRb;
            if (inst.InstImm) begin
              result_q <= inst.ImmData;
              state    <= WB;
            end else begin
              state    <= EXEC;
            end
          end
        end
        EXEC: begin
          result_q <= Fout;
          state    <= WB;
        end
        WB: begin
          Zero  <= (result_q == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Adata = exec_active ? ra_data : '0;
  assign Bdata = exec_active ? rb_data : '0;
  assign FS    = exec_active ? fs_q : '0;
  assign Done  = wb_active;

  datapath_sequencer_reg_file #(
    .DW(DW),
    .AW(AW)
  ) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_active),
    .wa       (rd_q),
    .wd       (result_q),
    .ra       (ra_q),
    .rb       (rb_q),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_addr (DbgAddr),
    .dbg_data (DbgData)
  );

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - table-driven bench for datapath_sequencer with a 4-bit function unit model
module tb_datapath_sequencer;
  import datapath_sequencer_pkg::*;

  localparam int DW = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] Adata;
  logic [DW-1:0] Bdata;
  logic [3:0]    FS;
  logic [DW-1:0] Fout;
  logic          Done;
  logic          Zero;
  logic [AW-1:0] DbgAddr;
  logic [DW-1:0] DbgData;

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  always #5 clk = ~clk;

  datapath_sequencer_if #(.DW(DW), .AW(AW)) inst_bus ();

  datapath_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .inst    (inst_bus),
    .Adata   (Adata),
    .Bdata   (Bdata),
    .FS      (FS),
    .Fout    (Fout),
    .Done    (Done),
    .Zero    (Zero),
    .DbgAddr (DbgAddr),
    .DbgData (DbgData)
  );

  // Function unit model
  always_comb begin
    Fout = Adata;
    case (FS)
      FS_ADD:  Fout = Adata + Bdata;
      FS_SUB:  Fout = Adata - Bdata;
      FS_AND:  Fout = Adata & Bdata;
      FS_XOR:  Fout = Adata ^ Bdata;
      default: Fout = Adata;
    endcase
  end

  always @(negedge clk) begin
    if (Done === 1'b1) done_count++;
  end

  typedef struct {
    logic       imm;
    logic [3:0] fs;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [3:0] data;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    logic [3:0] exp_res;
    logic       exp_zero;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic imm, input logic [3:0] fs, input logic [1:0] rd,
                       input logic [1:0] ra, input logic [1:0] rb, input logic [3:0] data);
    inst_bus.InstValid = 1'b1;
    inst_bus.InstImm   = imm;
    inst_bus.InstFS    = fs;
    inst_bus.InstRd    = rd;
    inst_bus.InstRa    = ra;
    inst_bus.InstRb    = rb;
    inst_bus.ImmData   = data;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    #1;
    while (inst_bus.InstReady !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk(name, 32'(inst_bus.InstReady), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    drive(v.imm, v.fs, v.rd, v.ra, v.rb, v.data);
    wait_ready($sformatf("v%0d_ready", idx));
    @(posedge clk);
    step();
    inst_bus.InstValid = 1'b0;
    if (!v.imm) begin
      chk($sformatf("v%0d_exec_a", idx), 32'(Adata), 32'(v.exp_a));
      chk($sformatf("v%0d_exec_b", idx), 32'(Bdata), 32'(v.exp_b));
      chk($sformatf("v%0d_exec_fs", idx), 32'(FS), 32'(v.fs));
      chk($sformatf("v%0d_exec_done", idx), 32'(Done), 32'd0);
      chk($sformatf("v%0d_exec_ready", idx), 32'(inst_bus.InstReady), 32'd0);
      step();
    end
    chk($sformatf("v%0d_wb_done", idx), 32'(Done), 32'd1);
    chk($sformatf("v%0d_wb_ready", idx), 32'(inst_bus.InstReady), 32'd0);
    chk($sformatf("v%0d_wb_adata", idx), 32'(Adata), 32'd0);
    step();
    chk($sformatf("v%0d_idle_done", idx), 32'(Done), 32'd0);
    DbgAddr = v.rd;
    #1;
    chk($sformatf("v%0d_result", idx), 32'(DbgData), 32'(v.exp_res));
    chk($sformatf("v%0d_zero", idx), 32'(Zero), 32'(v.exp_zero));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          imm   fs      rd ra rb data  a     b     res   zero
    vecs[0]  = '{1'b1, 4'h0,   1, 0, 0, 4'h3, 4'h0, 4'h0, 4'h3, 1'b0};
    vecs[1]  = '{1'b1, 4'h0,   2, 0, 0, 4'h5, 4'h0, 4'h0, 4'h5, 1'b0};
    vecs[2]  = '{1'b0, FS_ADD, 3, 1, 2, 4'h0, 4'h3, 4'h5, 4'h8, 1'b0};
    vecs[3]  = '{1'b1, 4'h0,   0, 0, 0, 4'hF, 4'h0, 4'h0, 4'hF, 1'b0};
    vecs[4]  = '{1'b1, 4'h0,   1, 0, 0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0};
    vecs[5]  = '{1'b0, FS_ADD, 0, 0, 1, 4'h0, 4'hF, 4'h1, 4'h0, 1'b1};
    vecs[6]  = '{1'b0, FS_XOR, 2, 2, 3, 4'h0, 4'h5, 4'h8, 4'hD, 1'b0};
    vecs[7]  = '{1'b1, 4'h0,   3, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[8]  = '{1'b0, FS_ADD, 2, 2, 2, 4'h0, 4'hD, 4'hD, 4'hA, 1'b0};
    vecs[9]  = '{1'b0, FS_SUB, 1, 2, 1, 4'h0, 4'hA, 4'h1, 4'h9, 1'b0};
    vecs[10] = '{1'b1, 4'h0,   3, 0, 0, 4'h6, 4'h0, 4'h0, 4'h6, 1'b0};

    rst = 1'b1;
    DbgAddr = '0;
    drive(1'b0, 4'h0, 2'd0, 2'd0, 2'd0, 4'h0);
    inst_bus.InstValid = 1'b0;

    step();
    chk("rst_ready_0", 32'(inst_bus.InstReady), 32'd0);
    step();
    chk("rst_ready_1", 32'(inst_bus.InstReady), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(inst_bus.InstReady), 32'd1);
    for (int a = 0; a < 4; a++) begin
      DbgAddr = 2'(a);
      #1;
      chk($sformatf("rst_reg%0d", a), 32'(DbgData), 32'd0);
    end
    chk("rst_adata", 32'(Adata), 32'd0);
    chk("rst_bdata", 32'(Bdata), 32'd0);
    chk("rst_fs", 32'(FS), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_zero", 32'(Zero), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
    end

    // Second instruction held valid through EXEC/WB of the first
    drive(1'b0, FS_ADD, 2'd1, 2'd1, 2'd1, 4'h0);
    wait_ready("bp_a_ready");
    @(posedge clk);
    step();
    drive(1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 4'h7);
    chk("bp_exec_a", 32'(Adata), 32'h9);
    chk("bp_exec_ready", 32'(inst_bus.InstReady), 32'd0);
    step();
    chk("bp_wb_done", 32'(Done), 32'd1);
    chk("bp_wb_ready", 32'(inst_bus.InstReady), 32'd0);
    DbgAddr = 2'd0;
    #1;
    chk("bp_r0_not_yet", 32'(DbgData), 32'd0);
    step();
    chk("bp_idle_done", 32'(Done), 32'd0);
    chk("bp_idle_ready", 32'(inst_bus.InstReady), 32'd1);
    DbgAddr = 2'd1;
    #1;
    chk("bp_r1", 32'(DbgData), 32'h2);
    @(posedge clk);
    step();
    inst_bus.InstValid = 1'b0;
    chk("bp_b_wb_done", 32'(Done), 32'd1);
    step();
    chk("bp_b_idle_done", 32'(Done), 32'd0);
    DbgAddr = 2'd0;
    #1;
    chk("bp_r0", 32'(DbgData), 32'h7);
    chk("bp_zero", 32'(Zero), 32'd0);
    chk("bp_done_count", 32'(done_count), 32'd12);

    // Reset lands in the EXEC cycle of R2 = R1 + R1
    drive(1'b0, FS_ADD, 2'd2, 2'd1, 2'd1, 4'h0);
    wait_ready("rm_ready");
    @(posedge clk);
    step();
    inst_bus.InstValid = 1'b0;
    chk("rm_exec_a", 32'(Adata), 32'h2);
    rst = 1'b1;
    #1;
    chk("rm_rst_ready", 32'(inst_bus.InstReady), 32'd0);
    step();
    chk("rm_rst_done", 32'(Done), 32'd0);
    rst = 1'b0;
    #1;
    chk("rm_idle_ready", 32'(inst_bus.InstReady), 32'd1);
    chk("rm_idle_done", 32'(Done), 32'd0);
    DbgAddr = 2'd2;
    #1;
    chk("rm_r2_cleared", 32'(DbgData), 32'd0);
    DbgAddr = 2'd0;
    #1;
    chk("rm_r0_cleared", 32'(DbgData), 32'd0);
    chk("rm_zero", 32'(Zero), 32'd0);
    step();
    chk("rm_still_no_done", 32'(Done), 32'd0);
    chk("rm_done_count", 32'(done_count), 32'd12);

    run_vec(vecs[10], 10);
    chk("final_done_count", 32'(done_count), 32'd13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
